password_rom_controller: RTL and testbench
==========================================

// Module: password_rom_controller
// PURPOSE
//  Second authentication stage, downstream of the user-ID ROM controller.
//  Once the user ID is accepted (id_ok, from GreenLed) it collects a 4-digit password one nibble per load pulse.
//  It fetches that user's stored password from the password ROM at base address {user_index,2'b00}.
//  It compares the two, allows MAX_TRIES attempts, then locks out. access_granted enables the game control unit.
// PARAMETERS
//  ROM_LAT    2  cycles from rom_addr update to valid rom_data (synchronous ROM)
//  MAX_TRIES  3  password attempts per login; range 1..3
// PORTS
//  clk             in   1  system clock; all logic on posedge
//  reset           in   1  synchronous, active-high; dominates every other input
//  id_ok           in   1  user ID authenticated (upstream GreenLed level)
//  user_index      in   5  matched user index (upstream address_out); sampled on IDLE->ENTER
//  pwd_inp         in   4  password digit from switches
//  load_pwd        in   1  single-cycle pulse: capture pwd_inp as next digit
//  logout          in   1  logout request from game control unit
//  rom_addr        out  7  password ROM address, registered
//  rom_data        in   4  password ROM read data
//  pwd_display     out  4  last digit entered; 4'hA when idle/cleared
//  access_granted  out  1  level: password matched
//  access_denied   out  1  one-cycle pulse per failed attempt
//  locked_out      out  1  level: attempts exhausted
//  tries_left      out  2  attempts remaining
// BEHAVIOUR
//  Reset: state=IDLE, rom_addr=0, pwd_display=4'hA, access_granted=0, access_denied=0, locked_out=0.
//  Reset also sets tries_left=MAX_TRIES and clears the entered and stored registers and the digit counter.
//  IDLE: id_ok=1 -> latch base={user_index,2'b00}, go ENTER.
//  ENTER: each load_pwd captures pwd_inp into entered[15-4k -: 4] (k=0 first = MSB) and sets pwd_display=pwd_inp.
//   The 4th capture -> FETCH with k=0.
//  FETCH: per digit k: rom_addr<=base+k, wait ROM_LAT cycles, capture rom_data into stored[15-4k -: 4].
//   Each digit takes ROM_LAT+1 cycles. After k=3 -> COMPARE.
//  load_pwd outside ENTER is ignored (FETCH, COMPARE, GRANTED, LOCKED).
//  COMPARE (1 cycle):
//   match -> GRANTED, access_granted=1.
//   mismatch with tries_left>1 -> tries_left-1, access_denied pulse (1 cycle), clear entered/stored, pwd_display=4'hA, back to ENTER.
//   mismatch with tries_left==1 -> tries_left=0, access_denied pulse, LOCKED, locked_out=1.
//  Latency: access_granted or access_denied rises 4*(ROM_LAT+1)+2 edges after the edge capturing the 4th digit.
//   This is 14 edges for ROM_LAT=2.
//  GRANTED and LOCKED hold until logout=1 or id_ok=0.
//  Exit to IDLE (logout=1 or id_ok=0, any state, 1 cycle): clear outputs as at reset and restore tries_left=MAX_TRIES.
//   rom_addr is left unchanged.
//  Simultaneous events: logout beats load_pwd; id_ok drop beats COMPARE; reset beats all.
//  A logout mid-FETCH aborts the fetch; no grant or deny is issued.
//  Address arithmetic: 7-bit, base+k never carries (k<=3). user_index=31 -> addresses 124..127.
// TESTING
//  1. Reset, id_ok=1, user_index=2, ROM[8..11]=3,7,1,9; load 3,7,1,9 -> rom_addr 8,9,10,11;
//     access_granted=1 exactly 14 edges after 4th load; tries_left=3.
//  2. Same user; enter 3,7,1,8 -> access_denied 1-cycle pulse, tries_left=2, pwd_display=A;
//     re-enter 3,7,1,9 -> granted.
//  3. Three wrong entries -> tries_left 2,1,0; locked_out=1; further load_pwd ignored;
//     logout -> IDLE, locked_out=0, tries_left=3.
//  4. user_index=31, ROM[124..127]=F,0,F,0; enter F,0,F,0 -> granted; check no address wrap.
//  5. logout during FETCH and logout with load_pwd in same cycle -> IDLE, no grant or deny, pwd_display=A.
//  6. Assert reset in GRANTED and mid-ENTER (2 digits loaded) -> all outputs at reset values next cycle;
//     full 4-digit entry then required.

Source files
------------

// File: rtl/password_rom_controller.sv
// ---------------------------------------------------------------------------
// password_rom_controller
//
// Second authentication stage. After the user ID is accepted (id_ok) the
// block collects a 4-digit password, one nibble per load_pwd pulse. It then
// reads the user's stored password from a synchronous password ROM at
// {user_index,2'b00}..+3 and compares the two. A match grants access. Each
// mismatch consumes one try, and the block locks out when no tries remain.
//
// Ports
//   clk            in   system clock, all logic on posedge
//   reset          in   synchronous active-high reset, dominates all inputs
//   id_ok          in   user ID authenticated (level); dropping it exits
//   user_index     in   matched user index, sampled on IDLE->ENTER
//   pwd_inp        in   password digit from switches
//   load_pwd       in   single-cycle pulse: capture pwd_inp as next digit
//   logout         in   logout request; exits to IDLE from any state
//   rom_addr       out  password ROM address (registered)
//   rom_data       in   password ROM read data, ROM_LAT cycles after rom_addr
//   pwd_display    out  last digit entered, 4'hA when idle/cleared
//   access_granted out  level: password matched
//   access_denied  out  one-cycle pulse per failed attempt
//   locked_out     out  level: attempts exhausted
//   tries_left     out  attempts remaining
//
// Handshake: there is no valid/ready pair. load_pwd is a one-cycle strobe
// that is consumed only in ENTER. rom_data is trusted exactly ROM_LAT+1
// edges after the edge that updated rom_addr. The next address is issued on
// that same capture edge, so one digit costs ROM_LAT+1 cycles.
// ---------------------------------------------------------------------------
module password_rom_controller #(
    parameter int ROM_LAT   = 2,
    parameter int MAX_TRIES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_ok,
    input  logic [4:0] user_index,
    input  logic [3:0] pwd_inp,
    input  logic       load_pwd,
    input  logic       logout,
    output logic [6:0] rom_addr,
    input  logic [3:0] rom_data,
    output logic [3:0] pwd_display,
    output logic       access_granted,
    output logic       access_denied,
    output logic       locked_out,
    output logic [1:0] tries_left
);

    localparam int WW = $clog2(ROM_LAT + 2);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        FETCH   = 3'd2,
        COMPARE = 3'd3,
        GRANTED = 3'd4,
        LOCKED  = 3'd5
    } state_t;

    state_t        state, state_n;
    logic [6:0]    base, base_n;
    logic [1:0]    k, k_n;          // digit index, shared by ENTER and FETCH
    logic [WW-1:0] w, w_n;          // ROM wait counter inside FETCH
    logic [15:0]   entered, entered_n;
    logic [15:0]   stored, stored_n;
    logic [6:0]    rom_addr_n;
    logic [3:0]    pwd_display_n;
    logic          access_granted_n, access_denied_n, locked_out_n;
    logic [1:0]    tries_left_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            base           <= '0;
            k              <= '0;
            w              <= '0;
            entered        <= '0;
            stored         <= '0;
            rom_addr       <= '0;
            pwd_display    <= 4'hA;
            access_granted <= 1'b0;
            access_denied  <= 1'b0;
            locked_out     <= 1'b0;
            tries_left     <= 2'(MAX_TRIES);
        end else begin
            state          <= state_n;
            base           <= base_n;
            k              <= k_n;
            w              <= w_n;
            entered        <= entered_n;
            stored         <= stored_n;
            rom_addr       <= rom_addr_n;
            pwd_display    <= pwd_display_n;
            access_granted <= access_granted_n;
            access_denied  <= access_denied_n;
            locked_out     <= locked_out_n;
            tries_left     <= tries_left_n;
        end
    end

    always_comb begin
        state_n          = state;
        base_n           = base;
        k_n              = k;
        w_n              = w;
        entered_n        = entered;
        stored_n         = stored;
        rom_addr_n       = rom_addr;
        pwd_display_n    = pwd_display;
        access_granted_n = access_granted;
        access_denied_n  = 1'b0;
        locked_out_n     = locked_out;
        tries_left_n     = tries_left;

        if (logout || !id_ok) begin
            // Exit wins over everything in flight, including a load_pwd or a
            // pending compare. rom_addr is deliberately left where it is.
            state_n          = IDLE;
            k_n              = '0;
            w_n              = '0;
            entered_n        = '0;
            stored_n         = '0;
            pwd_display_n    = 4'hA;
            access_granted_n = 1'b0;
            locked_out_n     = 1'b0;
            tries_left_n     = 2'(MAX_TRIES);
        end else begin
            case (state)
                IDLE: begin
                    base_n  = {user_index, 2'b00};
                    k_n     = '0;
                    state_n = ENTER;
                end
                ENTER: begin
                    if (load_pwd) begin
                        // 15-4k == {~k,2'b11}: digit 0 lands in the MSB nibble
                        entered_n[{~k, 2'b11} -: 4] = pwd_inp;
                        pwd_display_n               = pwd_inp;
                        if (k == 2'd3) begin
                            state_n = FETCH;
                            k_n     = '0;
                            w_n     = '0;
                        end else begin
                            k_n = k + 2'd1;
                        end
                    end
                end
                FETCH: begin
                    if (w == '0) begin
                        rom_addr_n = base + {5'b0, k};
                        w_n        = WW'(1);
                    end else if (w == WW'(ROM_LAT + 1)) begin
                        stored_n[{~k, 2'b11} -: 4] = rom_data;
                        if (k == 2'd3) begin
                            state_n = COMPARE;
                        end else begin
                            // base has zeros in its low two bits, so no carry
                            k_n        = k + 2'd1;
                            rom_addr_n = base + {5'b0, k + 2'd1};
                            w_n        = WW'(1);
                        end
                    end else begin
                        w_n = w + WW'(1);
                    end
                end
                COMPARE: begin
                    k_n = '0;
                    w_n = '0;
                    if (entered == stored) begin
                        state_n          = GRANTED;
                        access_granted_n = 1'b1;
                    end else if (tries_left > 2'd1) begin
                        state_n         = ENTER;
                        tries_left_n    = tries_left - 2'd1;
                        access_denied_n = 1'b1;
                        entered_n       = '0;
                        stored_n        = '0;
                        pwd_display_n   = 4'hA;
                    end else begin
                        state_n         = LOCKED;
                        tries_left_n    = 2'd0;
                        access_denied_n = 1'b1;
                        locked_out_n    = 1'b1;
                    end
                end
                GRANTED: state_n = GRANTED;
                LOCKED:  state_n = LOCKED;
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_password_rom_controller.sv
module tb_password_rom_controller;

    localparam int ROM_LAT   = 2;
    localparam int MAX_TRIES = 3;
    localparam int LAT       = 4 * (ROM_LAT + 1) + 2;

    logic       clk = 1'b0;
    logic       reset, id_ok, logout, load_pwd;
    logic [4:0] user_index;
    logic [3:0] pwd_inp, rom_data, pwd_display;
    logic [6:0] rom_addr;
    logic       access_granted, access_denied, locked_out;
    logic [1:0] tries_left;

    password_rom_controller #(.ROM_LAT(ROM_LAT), .MAX_TRIES(MAX_TRIES)) dut (
        .clk(clk), .reset(reset), .id_ok(id_ok), .user_index(user_index),
        .pwd_inp(pwd_inp), .load_pwd(load_pwd), .logout(logout),
        .rom_addr(rom_addr), .rom_data(rom_data), .pwd_display(pwd_display),
        .access_granted(access_granted), .access_denied(access_denied),
        .locked_out(locked_out), .tries_left(tries_left)
    );

    // ---------------- clock / reset / ROM model ----------------
    always #5 clk = ~clk;

    logic [3:0] mem [0:127];
    logic [3:0] rom_q1;
    always @(posedge clk) begin
        rom_q1   <= mem[rom_addr];
        rom_data <= rom_q1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          errors = 0;
    int          checks = 0;
    int          load_cyc = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Event word: {granted, denied, locked, 3'b0, tries, latency}
    function automatic logic [15:0] mk(input logic g, input logic d, input logic l,
                                        input logic [1:0] t);
        return {g, d, l, 3'b000, t, 8'(LAT)};
    endfunction

    logic prev_g = 1'b0;
    always @(negedge clk) begin
        logic [15:0] act;
        if ((access_granted === 1'b1 && prev_g === 1'b0) || access_denied === 1'b1) begin
            act = {access_granted, access_denied, locked_out, 3'b000, tries_left, 8'(cyc - load_cyc)};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got %h expected none", act);
            end else begin
                check("result_event", act, exp_q.pop_front());
            end
        end
        prev_g = access_granted;
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_vals(input string tag);
        check({tag, "_rom_addr"}, 16'(rom_addr), 16'd0);
        check({tag, "_display"}, 16'(pwd_display), 16'hA);
        check({tag, "_granted"}, 16'(access_granted), 16'd0);
        check({tag, "_denied"}, 16'(access_denied), 16'd0);
        check({tag, "_locked"}, 16'(locked_out), 16'd0);
        check({tag, "_tries"}, 16'(tries_left), 16'(MAX_TRIES));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals(tag);
        reset = 1'b0;
    endtask

    task automatic set_rom(input logic [4:0] u, input logic [15:0] word);
        for (int i = 0; i < 4; i++) mem[{u, 2'b00} + 7'(i)] = word[15 - 4 * i -: 4];
    endtask

    task automatic start_login(input logic [4:0] u);
        @(negedge clk);
        logout = 1'b1;
        @(negedge clk);
        logout     = 1'b0;
        id_ok      = 1'b1;
        user_index = u;
    endtask

    task automatic load_digit(input logic [3:0] d);
        @(negedge clk);
        pwd_inp  = d;
        load_pwd = 1'b1;
        @(posedge clk);
        #1;
        load_cyc = cyc;
        load_pwd = 1'b0;
    endtask

    task automatic enter_pwd(input logic [15:0] word);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            load_digit(word[15 - 4 * i -: 4]);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         new_login;
        logic [4:0] user;
        logic [15:0] stored;
        logic [15:0] typed;
        logic       g;
        logic       l;
        logic [1:0] t;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 5'd2,  16'h3719, 16'h3719, 1'b1, 1'b0, 2'd3};
        tbl[1] = '{1'b1, 5'd2,  16'h3719, 16'h3718, 1'b0, 1'b0, 2'd2};
        tbl[2] = '{1'b0, 5'd2,  16'h3719, 16'h3719, 1'b1, 1'b0, 2'd2};
        tbl[3] = '{1'b1, 5'd5,  16'hABCD, 16'h0000, 1'b0, 1'b0, 2'd2};
        tbl[4] = '{1'b0, 5'd5,  16'hABCD, 16'h1111, 1'b0, 1'b0, 2'd1};
        tbl[5] = '{1'b0, 5'd5,  16'hABCD, 16'h2222, 1'b0, 1'b1, 2'd0};
        tbl[6] = '{1'b1, 5'd31, 16'hF0F0, 16'hF0F0, 1'b1, 1'b0, 2'd3};
        tbl[7] = '{1'b1, 5'd0,  16'h0000, 16'h0000, 1'b1, 1'b0, 2'd3};
        tbl[8] = '{1'b1, 5'd17, 16'h5A3C, 16'h5A3D, 1'b0, 1'b0, 2'd2};
        tbl[9] = '{1'b0, 5'd17, 16'h5A3C, 16'h5A3C, 1'b1, 1'b0, 2'd2};

        for (int i = 0; i < 128; i++) mem[i] = 4'($urandom_range(0, 15));
        reset      = 1'b1;
        id_ok      = 1'b0;
        logout     = 1'b0;
        load_pwd   = 1'b0;
        pwd_inp    = 4'h0;
        user_index = 5'd0;
        @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;

        for (int r = 0; r < 10; r++) begin
            if (tbl[r].new_login) begin
                set_rom(tbl[r].user, tbl[r].stored);
                start_login(tbl[r].user);
            end
            enter_pwd(tbl[r].typed);
            exp_q.push_back(mk(tbl[r].g, !tbl[r].g, tbl[r].l, tbl[r].t));
            wait_drain();
            @(negedge clk);
            check($sformatf("row%0d_granted", r), 16'(access_granted), 16'(tbl[r].g));
            check($sformatf("row%0d_denied_pulse", r), 16'(access_denied), 16'd0);
            check($sformatf("row%0d_locked", r), 16'(locked_out), 16'(tbl[r].l));
            check($sformatf("row%0d_tries", r), 16'(tries_left), 16'(tbl[r].t));
            check($sformatf("row%0d_display", r), 16'(pwd_display),
                  (tbl[r].g || tbl[r].l) ? 16'(tbl[r].typed[3:0]) : 16'hA);
            check($sformatf("row%0d_last_addr", r), 16'(rom_addr), 16'({tbl[r].user, 2'b11}));
            if (tbl[r].l) begin
                // Loads while locked must change nothing and raise no event
                enter_pwd(16'h1234);
                repeat (20) @(negedge clk);
                check("locked_ignore_display", 16'(pwd_display), 16'(tbl[r].typed[3:0]));
                check("locked_ignore_tries", 16'(tries_left), 16'd0);
                check("locked_hold", 16'(locked_out), 16'd1);
                @(negedge clk);
                logout = 1'b1;
                @(negedge clk);
                logout = 1'b0;
                check("unlock_locked", 16'(locked_out), 16'd0);
                check("unlock_tries", 16'(tries_left), 16'(MAX_TRIES));
                check("unlock_display", 16'(pwd_display), 16'hA);
            end
        end

        // Logout in the middle of the ROM fetch: no grant or deny afterwards
        set_rom(5'd3, 16'h4242);
        start_login(5'd3);
        enter_pwd(16'h4242);
        repeat (4) @(negedge clk);
        logout = 1'b1;
        @(negedge clk);
        logout = 1'b0;
        check("fetch_abort_display", 16'(pwd_display), 16'hA);
        check("fetch_abort_tries", 16'(tries_left), 16'(MAX_TRIES));
        repeat (20) @(negedge clk);
        check("fetch_abort_no_grant", 16'(access_granted), 16'd0);

        // Logout and load_pwd in the same cycle: logout wins
        load_digit(4'h4);
        load_digit(4'h2);
        @(negedge clk);
        pwd_inp  = 4'h7;
        load_pwd = 1'b1;
        logout   = 1'b1;
        @(negedge clk);
        load_pwd = 1'b0;
        logout   = 1'b0;
        check("logout_load_display", 16'(pwd_display), 16'hA);
        enter_pwd(16'h4242);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd3));
        wait_drain();

        // Dropping id_ok in GRANTED returns to IDLE
        @(negedge clk);
        id_ok = 1'b0;
        @(negedge clk);
        check("idok_drop_granted", 16'(access_granted), 16'd0);
        check("idok_drop_display", 16'(pwd_display), 16'hA);
        id_ok = 1'b1;

        // Reset while GRANTED, then reset mid-ENTER after two digits
        enter_pwd(16'h4242);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd3));
        wait_drain();
        do_reset("rst_granted");
        load_digit(4'h1);
        load_digit(4'h1);
        do_reset("rst_enter");
        enter_pwd(16'h4242);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 2'd3));
        wait_drain();
        @(negedge clk);
        check("after_reset_granted", 16'(access_granted), 16'd1);

        repeat (5) @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
